// File: rtl/panel_layer_sequencer_pkg.sv
// Shared FSM encoding, pixel field layout and the per-channel blend helper
// for the panel layer sequencer.
package panel_layer_sequencer_pkg;

   localparam int unsigned COORD_W = 10;
   localparam int unsigned CH_W    = 8;
   localparam int unsigned NUM_CH  = 3;
   localparam int unsigned RGB_W   = CH_W * NUM_CH;
   localparam int unsigned RGBA_W  = CH_W * (NUM_CH + 1);
   // {r,g,b,a}: alpha in the low byte, colour channels shifted up by one byte
   localparam int unsigned A_OFF   = 0;
   localparam int unsigned C_OFF   = CH_W;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_TICK = 3'd1,
      S_REQ  = 3'd2,
      S_WAIT = 3'd3,
      S_OUT  = 3'd4
   } seq_state_t;

   function automatic logic [CH_W-1:0] blend_ch(
      input logic [CH_W-1:0] i_src,
      input logic [CH_W-1:0] i_dst,
      input logic [CH_W-1:0] i_a
   );
      logic [16:0] w_sum;
      w_sum = ({9'd0, i_src} * {9'd0, i_a}) + ({9'd0, i_dst} * {9'd0, ~i_a});
      return CH_W'(w_sum >> 8);
   endfunction

endpackage

// File: rtl/panel_alpha_blend.sv
// Combinational source-over blend of one RGBA layer onto an RGB accumulator.
module panel_alpha_blend
   import panel_layer_sequencer_pkg::*;
(
   input  logic [RGBA_W-1:0] i_src_rgba,
   input  logic [RGB_W-1:0]  i_dst_rgb,
   output logic [RGB_W-1:0]  o_rgb
);

   logic [CH_W-1:0] w_a;

   assign w_a = i_src_rgba[A_OFF +: CH_W];

   always_comb begin
      o_rgb = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         o_rgb[CH_W*c +: CH_W] = blend_ch(i_src_rgba[C_OFF + CH_W*c +: CH_W],
                                          i_dst_rgb[CH_W*c +: CH_W], w_a);
      end
   end

endmodule

// File: rtl/panel_layer_sequencer.sv
// Raster scheduler and compositor for a stack of panel layer generators.
// Optional per-layer response timeout: define PANEL_SEQ_TIMEOUT_EN.
module panel_layer_sequencer
   import panel_layer_sequencer_pkg::*;
#(
   parameter int unsigned NUM_LAYERS     = 4,
   parameter int unsigned H_PIXELS       = 64,
   parameter int unsigned V_PIXELS       = 32,
   parameter logic [23:0] BG_RGB         = 24'h0,
   parameter int unsigned TIMEOUT_CYCLES = 255
)
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         run,
   output logic [NUM_LAYERS-1:0]        lay_valid,
   output logic                         lay_tick,
   output logic [COORD_W-1:0]           lay_x,
   output logic [COORD_W-1:0]           lay_y,
   input  logic [NUM_LAYERS-1:0]        lay_ready,
   input  logic [NUM_LAYERS-1:0]        lay_vout,
   output logic [NUM_LAYERS-1:0]        lay_ack,
   input  logic [RGBA_W*NUM_LAYERS-1:0] lay_rgba,
   output logic                         pix_valid,
   input  logic                         pix_ready,
   output logic [COORD_W-1:0]           pix_x,
   output logic [COORD_W-1:0]           pix_y,
   output logic [RGB_W-1:0]             pix_rgb,
   output logic                         frame_done,
   output logic                         err
);

   localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   seq_state_t          r_state, w_state_nxt;
   logic [COORD_W-1:0]  r_x, r_y;
   logic [IDX_W-1:0]    r_idx;
   logic [RGB_W-1:0]    r_acc;
   logic                r_frame_done;

   logic [NUM_LAYERS-1:0] w_lay_valid, w_lay_ack;
   logic                  w_lay_tick, w_pix_valid;
   logic                  w_blend_en, w_skip, w_accept, w_timeout;
   logic                  w_last_layer, w_last_x, w_last_y, w_last_pix;
   logic [RGB_W-1:0]      w_blend_rgb;

   assign w_last_layer = (r_idx == IDX_W'(NUM_LAYERS - 1));
   assign w_last_x     = (r_x == COORD_W'(H_PIXELS - 1));
   assign w_last_y     = (r_y == COORD_W'(V_PIXELS - 1));
   assign w_last_pix   = w_last_x && w_last_y;

   panel_alpha_blend u_blend (
      .i_src_rgba (lay_rgba[RGBA_W*r_idx +: RGBA_W]),
      .i_dst_rgb  (r_acc),
      .o_rgb      (w_blend_rgb)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_lay_valid = '0;
      w_lay_tick  = 1'b0;
      w_lay_ack   = '0;
      w_pix_valid = 1'b0;
      w_blend_en  = 1'b0;
      w_skip      = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: if (run) w_state_nxt = S_TICK;
         S_TICK: begin
            w_lay_valid = '1;
            w_lay_tick  = 1'b1;
            w_state_nxt = S_REQ;
         end
         S_REQ: begin
            w_lay_valid[r_idx] = 1'b1;
            if (lay_ready[r_idx]) w_state_nxt = S_WAIT;
            else if (w_timeout)   w_skip      = 1'b1;
         end
         S_WAIT: begin
            w_lay_ack[r_idx] = lay_vout[r_idx];
            if (lay_vout[r_idx]) w_blend_en = 1'b1;
            else if (w_timeout)  w_skip     = 1'b1;
         end
         S_OUT: begin
            w_pix_valid = 1'b1;
            if (pix_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = w_last_pix ? (run ? S_TICK : S_IDLE) : S_REQ;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_blend_en || w_skip) w_state_nxt = w_last_layer ? S_OUT : S_REQ;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_x          <= '0;
         r_y          <= '0;
         r_idx        <= '0;
         r_acc        <= BG_RGB;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_frame_done <= w_accept && w_last_pix;
         if (r_state == S_TICK) begin
            r_idx <= '0;
            r_acc <= BG_RGB;
         end
         if (w_blend_en) r_acc <= w_blend_rgb;
         if ((w_blend_en || w_skip) && !w_last_layer) r_idx <= r_idx + 1'b1;
         if (w_accept) begin
            r_idx <= '0;
            r_acc <= BG_RGB;
            if (w_last_x) begin
               r_x <= '0;
               r_y <= w_last_y ? '0 : r_y + 1'b1;
            end else begin
               r_x <= r_x + 1'b1;
            end
         end
      end
   end

`ifdef PANEL_SEQ_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_err;

   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counts REQ and WAIT cycles together for the layer currently being served
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if ((r_state == S_REQ || r_state == S_WAIT) && !(w_blend_en || w_skip))
            r_cnt <= r_cnt + 1'b1;
         else
            r_cnt <= '0;
         if (w_skip) r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   logic w_unused_cfg;

   assign w_unused_cfg = ^TIMEOUT_CYCLES;
   assign w_timeout    = 1'b0;
   assign err          = 1'b0;
`endif

   assign lay_valid  = w_lay_valid;
   assign lay_tick   = w_lay_tick;
   assign lay_ack    = w_lay_ack;
   assign lay_x      = r_x;
   assign lay_y      = r_y;
   assign pix_valid  = w_pix_valid;
   assign pix_x      = r_x;
   assign pix_y      = r_y;
   assign pix_rgb    = (r_state == S_OUT) ? r_acc : '0;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_panel_layer_sequencer.sv
// Scoreboard bench for panel_layer_sequencer: 2 layers, 4x2 frame.
// The timeout scenario runs only when PANEL_SEQ_TIMEOUT_EN is defined.
module tb_panel_layer_sequencer;

   logic        clk, rst_n, run;
   logic [1:0]  lay_valid, lay_ready, lay_vout, lay_ack;
   logic        lay_tick, pix_valid, pix_ready, frame_done, err;
   logic [9:0]  lay_x, lay_y, pix_x, pix_y;
   logic [63:0] lay_rgba;
   logic [23:0] pix_rgb;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [23:0] rgb;
   } pix_t;

   pix_t q[$];
   int   checks = 0, failures = 0;
   int   cyc = 0, tick_cnt = 0, fd_cnt = 0, pix_acc_cnt = 0;
   int   exp_acks[2];
   bit   lat_chk = 0;
   bit [1:0] mute = '0;

   panel_layer_sequencer #(
      .NUM_LAYERS     (2),
      .H_PIXELS       (4),
      .V_PIXELS       (2),
      .BG_RGB         (24'h0),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .lay_valid  (lay_valid),
      .lay_tick   (lay_tick),
      .lay_x      (lay_x),
      .lay_y      (lay_y),
      .lay_ready  (lay_ready),
      .lay_vout   (lay_vout),
      .lay_ack    (lay_ack),
      .lay_rgba   (lay_rgba),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_rgb    (pix_rgb),
      .frame_done (frame_done),
      .err        (err)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_frame(input logic [23:0] rgb);
      for (int y = 0; y < 2; y++)
         for (int x = 0; x < 4; x++)
            q.push_back('{x: 10'(x), y: 10'(y), rgb: rgb});
   endtask

   task automatic wait_ticks(input int target, input string nm);
      int n = 0;
      while (tick_cnt < target && n < 3000) begin @(posedge clk); #1; n++; end
      chk(nm, tick_cnt, target);
   endtask

   task automatic wait_fd(input int target, input string nm);
      int n = 0;
      while (fd_cnt < target && n < 3000) begin @(posedge clk); #1; n++; end
      chk(nm, fd_cnt, target);
   endtask

   task automatic wait_req1(input bit need_ready, input string nm);
      int n = 0;
      while (!(lay_valid == 2'b10 && !lay_tick && (!need_ready || lay_ready[1])) && n < 500) begin
         @(posedge clk); #1; n++;
      end
      chk(nm, lay_valid, 2'b10);
   endtask

   task automatic idle_check(input int t_exp, input int f_exp, input string nm);
      repeat (20) @(posedge clk);
      #1;
      chk({nm, "_idle"}, {lay_valid, pix_valid}, 0);
      chk({nm, "_ticks"}, tick_cnt, t_exp);
      chk({nm, "_frame_done"}, fd_cnt, f_exp);
      chk({nm, "_queue_left"}, q.size(), 0);
   endtask

   // Layer responders: a request accepted in cycle c yields lay_vout in c+1,
   // held until acked.
   initial begin
      logic [1:0] acc_req, acked;
      lay_vout = '0;
      forever begin
         @(negedge clk);
         acc_req = lay_valid & lay_ready & {2{~lay_tick}};
         acked   = lay_ack;
         @(posedge clk);
         #1;
         if (!rst_n) lay_vout = '0;
         else        lay_vout = (lay_vout & ~acked) | (acc_req & ~mute);
      end
   end

   // Monitor: pops the scoreboard on each accepted pixel; checks holds and acks.
   initial begin
      bit prev_lstall, prev_pstall;
      logic [21:0] prev_lay;
      logic [44:0] prev_pix;
      int acks[2];
      int last_acc;
      pix_t e;
      prev_lstall = 0; prev_pstall = 0; acks = '{0, 0}; last_acc = -1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            acks = '{0, 0}; prev_lstall = 0; prev_pstall = 0; last_acc = -1;
            continue;
         end
         if (prev_lstall) chk("lay_hold", {lay_valid, lay_x, lay_y}, prev_lay);
         if (prev_pstall) chk("pix_hold", {pix_valid, pix_x, pix_y, pix_rgb}, prev_pix);
         if (lay_tick) begin
            tick_cnt++;
            chk("tick_allones", lay_valid, 2'b11);
            chk("tick_xy", {lay_x, lay_y}, 0);
         end
         if (lay_ack != 0) chk("ack_without_vout", lay_ack & ~lay_vout, 0);
         for (int j = 0; j < 2; j++) if (lay_ack[j]) acks[j]++;
         if (frame_done) fd_cnt++;
         if (pix_valid && pix_ready) begin
            chk("pix_queue_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("pix_xy", {pix_x, pix_y}, {e.x, e.y});
               chk("pix_rgb", pix_rgb, e.rgb);
            end
            chk("acks_layer0", acks[0], exp_acks[0]);
            chk("acks_layer1", acks[1], exp_acks[1]);
            acks = '{0, 0};
            if (lat_chk && last_acc >= 0 && !(pix_x == 0 && pix_y == 0))
               chk("pix_gap", cyc - last_acc, 5);
            last_acc = cyc;
            pix_acc_cnt++;
         end
         prev_lstall = (lay_valid != 0) && !lay_tick && ((lay_valid & lay_ready) == 0);
         prev_lay    = {lay_valid, lay_x, lay_y};
         prev_pstall = pix_valid && !pix_ready;
         prev_pix    = {pix_valid, pix_x, pix_y, pix_rgb};
      end
   end

   initial begin
      int t0, f0, a0, n;
      rst_n = 0; run = 0; lay_ready = '1; pix_ready = 1; lay_rgba = '0;
      exp_acks = '{1, 1};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", {lay_valid, lay_tick, lay_ack, pix_valid, pix_rgb, frame_done, err}, 0);
      chk("rst_coords", {lay_x, lay_y, pix_x, pix_y}, 0);
      rst_n = 1;
      repeat (4) @(posedge clk);
      #1;
      chk("idle_without_run", {lay_valid, pix_valid}, 0);

      // 1: alpha FF then 00; expected 0E7EFD, back-to-back pixels 5 cycles apart
      lay_rgba = {32'hAABBCC00, 32'h1080FFFF};
      lat_chk = 1;
      push_frame(24'h0E7EFD);
      t0 = tick_cnt; f0 = fd_cnt;
      run = 1;
      wait_ticks(t0 + 1, "t1_tick");
      run = 0;
      wait_fd(f0 + 1, "t1_done");
      idle_check(t0 + 1, f0 + 1, "t1");
      lat_chk = 0;

      // 2+3: red a=FF under blue a=80 -> 7E007F, with layer and pixel stalls
      lay_rgba = {32'h0000FF80, 32'hFF0000FF};
      lay_ready[1] = 0; pix_ready = 0;
      push_frame(24'h7E007F);
      t0 = tick_cnt; f0 = fd_cnt;
      run = 1;
      wait_ticks(t0 + 1, "t2_tick");
      run = 0;
      wait_req1(0, "t3_req1_seen");
      repeat (4) @(posedge clk);
      #1;
      lay_ready[1] = 1;
      n = 0;
      while (!pix_valid && n < 500) begin @(posedge clk); #1; n++; end
      chk("t3_pix_seen", pix_valid, 1);
      repeat (2) @(posedge clk);
      #1;
      pix_ready = 1;
      wait_fd(f0 + 1, "t2_done");
      idle_check(t0 + 1, f0 + 1, "t2");

      // 4: two frames, run drops at the third pixel of the second
      lay_rgba = {32'hAABBCC00, 32'h1080FFFF};
      lat_chk = 1;
      push_frame(24'h0E7EFD);
      push_frame(24'h0E7EFD);
      t0 = tick_cnt; f0 = fd_cnt;
      run = 1;
      wait_fd(f0 + 1, "t4_first_done");
      a0 = pix_acc_cnt;
      n = 0;
      while (pix_acc_cnt < a0 + 3 && n < 500) begin @(posedge clk); #1; n++; end
      chk("t4_third_pixel", pix_acc_cnt, a0 + 3);
      run = 0;
      wait_fd(f0 + 2, "t4_second_done");
      idle_check(t0 + 2, f0 + 2, "t4");
      lat_chk = 0;

      // 5: reset while waiting on layer 1, then restart from (0,0)
      mute[1] = 1;
      run = 1;
      wait_req1(1, "t5_req1_accept");
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      chk("t5_async_outputs", {lay_valid, lay_tick, lay_ack, pix_valid, pix_rgb, frame_done}, 0);
      chk("t5_async_coords", {lay_x, lay_y, pix_x, pix_y}, 0);
      repeat (2) @(posedge clk);
      #1;
      mute[1] = 0;
      push_frame(24'h0E7EFD);
      t0 = tick_cnt; f0 = fd_cnt;
      rst_n = 1;
      wait_ticks(t0 + 1, "t5_restart_tick");
      run = 0;
      wait_fd(f0 + 1, "t5_done");
      idle_check(t0 + 1, f0 + 1, "t5");

`ifdef PANEL_SEQ_TIMEOUT_EN
      // 6: layer 1 silent -> skipped after 8 cycles, layer-0-only colour
      lay_rgba = {32'h0000FF80, 32'hFF0000FF};
      mute[1] = 1;
      exp_acks = '{1, 0};
      push_frame(24'hFE0000);
      t0 = tick_cnt; f0 = fd_cnt;
      run = 1;
      wait_ticks(t0 + 1, "t6_tick");
      run = 0;
      wait_req1(0, "t6_req1_seen");
      repeat (7) @(posedge clk);
      #1;
      chk("t6_err_before_limit", err, 0);
      @(posedge clk);
      #1;
      chk("t6_err_at_limit", err, 1);
      wait_fd(f0 + 1, "t6_done");
      idle_check(t0 + 1, f0 + 1, "t6");
      chk("t6_err_sticky", err, 1);
`else
      chk("err_tied_low", err, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
